// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   req_id_e     : identifies which requester owns the memory port this cycle
//   rsp_state_e  : per-requester response FSM state
//   IF_READ_ONLY : the instruction-fetch requester never writes memory
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  typedef enum logic {
    RSP_IDLE  = 1'b0,
    RSP_VALID = 1'b1
  } rsp_state_e;

  localparam bit IF_READ_ONLY = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch (IF), load/store (LS) and memory-side signals of the
// memory port arbiter.
//   modport slave  : arbiter view (takes requests and mem read data, drives
//                    grants, responses and memory controls)
//   modport master : requester/memory view (the opposite directions)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  localparam int SWIDTH = DWIDTH / 8;

  // Instruction fetch
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rsp_vld_o;
  logic [DWIDTH-1:0] if_rsp_data_o;
  // Load/store
  logic              ls_req_i;
  logic              ls_we_i;
  logic [AWIDTH-1:0] ls_addr_i;
  logic [DWIDTH-1:0] ls_data_i;
  logic [SWIDTH-1:0] ls_strb_i;
  logic              ls_gnt_o;
  logic              ls_rsp_vld_o;
  logic [DWIDTH-1:0] ls_rsp_data_o;
  // Memory
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic [SWIDTH-1:0] mem_strb_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_strb_i,
    input  mem_data_i,
    output if_gnt_o, if_rsp_vld_o, if_rsp_data_o,
    output ls_gnt_o, ls_rsp_vld_o, ls_rsp_data_o,
    output mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_strb_i,
    output mem_data_i,
    input  if_gnt_o, if_rsp_vld_o, if_rsp_data_o,
    input  ls_gnt_o, ls_rsp_vld_o, ls_rsp_data_o,
    input  mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_rsp_reg.sv
// -----------------------------------------------------------------------------
// mem_arb_rsp_reg
// Per-requester response stage: goes RESP for exactly the cycle after each
// grant and captures the memory read data (or zero for a write ack) on that
// edge. The data register holds while no response is valid.
//   clk, rst    : clock, asynchronous active-high reset
//   i_gnt       : requester granted this cycle
//   i_is_write  : the granted access is a write (response data is zero)
//   i_rdata     : combinational read data from memory
//   o_rsp_vld   : response valid
//   o_rsp_data  : response data
// -----------------------------------------------------------------------------
module mem_arb_rsp_reg
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_gnt,
  input  logic              i_is_write,
  input  logic [DWIDTH-1:0] i_rdata,
  output logic              o_rsp_vld,
  output logic [DWIDTH-1:0] o_rsp_data
);

  rsp_state_e        r_state;
  rsp_state_e        w_state_nxt;
  logic [DWIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RSP_IDLE;
    else     r_state <= w_state_nxt;
  end

  // IDLE -> RESP on a grant; RESP -> RESP on a back-to-back grant.
  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = RSP_IDLE;
    case (r_state)
      RSP_IDLE:  if (i_gnt) w_state_nxt = RSP_VALID;
      RSP_VALID: if (i_gnt) w_state_nxt = RSP_VALID;
      default:   w_state_nxt = RSP_IDLE;
    endcase
  end

  // NOTE: this is a plain register, not a memory array, and its reset value is
  // visible on the port, so it is reset along with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_data <= '0;
    else if (i_gnt) r_data <= i_is_write ? '0 : i_rdata;
  end

  assign o_rsp_vld  = (r_state == RSP_VALID);
  assign o_rsp_data = r_data;

endmodule : mem_arb_rsp_reg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one byte-addressable memory port between instruction fetch (IF,
// read-only) and load/store (LS, read/write). At most one access is granted per
// cycle; LS wins conflicts unless IF has already lost STARVE_LIMIT times in a
// row. Read data is returned through a registered per-requester response one
// cycle after the grant.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : IF/LS request, grant and response signals plus the
//                       memory address/data/strobe/enable signals
//   stat_conflicts_o  : cycles with both requests high (MEM_ARB_STATS_EN only)
//   stat_forced_o     : starvation-forced IF wins (MEM_ARB_STATS_EN only)
// Build option: define MEM_ARB_STATS_EN to add the two wrapping statistics
// counters; arbitration is unaffected.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]        stat_conflicts_o,
  output logic [31:0]        stat_forced_o,
`endif
  mem_port_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1) begin : g_chk_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end
  if ((2 ** CNT_WIDTH) - 1 < STARVE_LIMIT) begin : g_chk_cnt
    $error("mem_port_arbiter: CNT_WIDTH too small to hold STARVE_LIMIT");
  end
  // The IF path below has no write datapath.
  if (!IF_READ_ONLY) begin : g_chk_if_ro
    $error("mem_port_arbiter: IF requester must be read-only");
  end

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic                 w_both_req;
  logic                 w_force_if;
  logic                 w_if_gnt;
  logic                 w_ls_gnt;
  req_id_e              w_winner;
  logic [CNT_WIDTH-1:0] r_starve_cnt;

  // Grants are masked during reset so every grant output reads 0 in reset.
  always_comb begin
    w_both_req = !rst && bus.if_req_i && bus.ls_req_i;
    w_force_if = w_both_req && (r_starve_cnt == LIMIT);
    w_if_gnt   = !rst && bus.if_req_i && (!bus.ls_req_i || w_force_if);
    w_ls_gnt   = !rst && bus.ls_req_i && !w_if_gnt;
    w_winner   = w_if_gnt ? REQ_IF : REQ_LS;
  end

  assign bus.if_gnt_o = w_if_gnt;
  assign bus.ls_gnt_o = w_ls_gnt;

  // Consecutive IF losses; any IF win or idle IF cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req_i || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Memory-side controls; everything is zero when nothing is granted. Write
  // data and strobes are only presented for writes.
  always_comb begin
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_strb_o     = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    if (w_if_gnt || w_ls_gnt) begin
      case (w_winner)
        REQ_IF: begin
          bus.mem_addr_o    = bus.if_addr_i;
          bus.mem_read_en_o = 1'b1;
        end
        REQ_LS: begin
          bus.mem_addr_o = bus.ls_addr_i;
          if (bus.ls_we_i) begin
            bus.mem_write_en_o = 1'b1;
            bus.mem_data_o     = bus.ls_data_i;
            bus.mem_strb_o     = bus.ls_strb_i;
          end else begin
            bus.mem_read_en_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mem_arb_rsp_reg #(.DWIDTH(DWIDTH)) u_if_rsp (
    .clk       (clk),
    .rst       (rst),
    .i_gnt     (w_if_gnt),
    .i_is_write(1'b0),
    .i_rdata   (bus.mem_data_i),
    .o_rsp_vld (bus.if_rsp_vld_o),
    .o_rsp_data(bus.if_rsp_data_o)
  );

  mem_arb_rsp_reg #(.DWIDTH(DWIDTH)) u_ls_rsp (
    .clk       (clk),
    .rst       (rst),
    .i_gnt     (w_ls_gnt),
    .i_is_write(bus.ls_we_i),
    .i_rdata   (bus.mem_data_i),
    .o_rsp_vld (bus.ls_rsp_vld_o),
    .o_rsp_data(bus.ls_rsp_data_o)
  );

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_forced;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      if (w_both_req) r_stat_conflicts <= r_stat_conflicts + 32'd1;
      if (w_force_if) r_stat_forced    <= r_stat_forced + 32'd1;
    end
  end

  assign stat_conflicts_o = r_stat_conflicts;
  assign stat_forced_o    = r_stat_forced;
`endif

endmodule : mem_port_arbiter
